key_spi_loader: RTL
===================

KEY_SPI_LOADER -- requirements
Module: key_spi_loader

Interface
REQ-001 SHALL have port clk, input, 1, system clock.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port cs_n, input, 1, SPI frame select (low = frame active), synchronous to clk.
REQ-004 SHALL have port rx_vld, input, 1, one-cycle strobe: rx_byte holds a complete received byte.
REQ-005 SHALL have port rx_byte, input, 8, received byte, MSB-first order.
REQ-006 SHALL have port tx_byte, output, 8, byte the SPI shifter transmits on the next byte slot.
REQ-007 SHALL have port wr_en, output, 1, one-cycle key-register write strobe.
REQ-008 SHALL have port wr_d, output, 32, key word to write.
REQ-009 SHALL have port wrd_id, output, 3, key slot id.
REQ-010 SHALL have port wrd_sk, output, 1, bank select (0 = k, 1 = psk).
REQ-011 SHALL have port wr_addr, output, 3, word index within the bank for writes.
REQ-012 SHALL have port rd_addr, output, 3, word index within the bank for reads.
REQ-013 SHALL have port rd_d, input, 32, combinational read data from the key register file.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse when a frame ends on a partial word.

Function
REQ-016 SHALL implement states IDLE, CMD, WDATA and RDATA.
REQ-017 SHALL go IDLE->CMD on the cycle cs_n is sampled low.
REQ-018 SHALL, in CMD on rx_vld, decode the command byte: [7] = rw (1 = write), [6:4] = id, [3] = sk, [2:0] = start word address.
REQ-019 SHALL register id, sk and address on the command byte, then go to WDATA (rw = 1) or RDATA (rw = 0).
REQ-020 SHALL, in WDATA, shift each rx_byte into a 32-bit assembler MSB-first, with a 2-bit byte counter.
REQ-021 SHALL, on the 4th byte of a word, pulse wr_en on the next cycle with the complete word on wr_d and the current word address on wr_addr.
REQ-022 SHALL increment the word address by one after each completed word, wrapping 7->0 with id and sk unchanged (burst).
REQ-023 SHALL, in RDATA, drive rd_addr with the current word address and update tx_byte one cycle after each rx_vld.
REQ-024 SHALL source each RDATA tx_byte from rd_d MSB byte first; the first word byte SHALL be valid one cycle after the command byte.
REQ-025 SHALL ignore received data bytes in RDATA and advance the address after the 4th transmitted byte, with the same 7->0 wrap.
REQ-026 SHALL hold tx_byte at 8'h00 outside RDATA.
REQ-027 SHALL, when cs_n is sampled high in any state, return to IDLE within one cycle and clear the byte counter.
REQ-028 SHALL drop a partially assembled write word without writing it, and SHALL pulse frame_err when cs_n rises in WDATA with byte counter != 0.
REQ-029 SHALL give cs_n high priority when cs_n high and rx_vld arrive in the same cycle: discard the byte and treat it as end of frame.
REQ-030 SHALL never assert wr_en for more than one cycle per word, and never outside WDATA.

Reset
REQ-031 SHALL, on rst_n low, set state IDLE, counters 0, assembler 0, and all outputs 0 (tx_byte 8'h00, wr_en 0, busy 0, frame_err 0).
REQ-032 SHALL, on reset mid-frame, abandon the frame with no write issued, and SHALL require cs_n high then low before a new frame is accepted.

Configuration
REQ-033 SHALL honour macro KEY_READBACK_EN: when defined, RDATA behaves per REQ-023..025.
REQ-034 SHALL, without KEY_READBACK_EN, still enter and sequence RDATA, but hold tx_byte at 8'h00 and rd_addr at 3'd0, so key material is never exposed.

Structure
REQ-035 SHALL place the state enum, the command-field bit positions and the tx idle value 8'h00 in shared package key_spi_pkg.
REQ-036 SHALL implement the shift register and byte counter in one sub-module, key_word_asm; all other logic stays flat.

Verification
REQ-037 SHALL cover this case: cs_n low, cmd 8'hA2, bytes 11 22 33 44 -> one wr_en pulse with wr_d = 32'h11223344, wrd_id = 2, wrd_sk = 0, wr_addr = 2.
REQ-038 SHALL cover this case: cmd 8'h9F then 8 bytes -> writes at wr_addr 7 then 0 (wrap), id = 1, sk = 1.
REQ-039 SHALL cover this case: KEY_READBACK_EN defined, rd_d = 32'hDEADBEEF, cmd 8'h30, 4 dummy bytes -> tx_byte sequence DE AD BE EF, then rd_addr = 1.
REQ-040 SHALL cover this case: cmd 8'h80, 2 bytes, then cs_n high -> no wr_en, one frame_err pulse, state IDLE.
REQ-041 SHALL cover this case: KEY_READBACK_EN undefined, read cmd 8'h00 -> tx_byte stays 8'h00 and rd_addr stays 0.
REQ-042 SHALL cover this case: rst_n pulsed low after 3 write data bytes -> all outputs 0 and no wr_en ever asserted.

Source files
------------

// File: rtl/key_spi_pkg.sv
// Shared definitions for the SPI key loader: FSM encoding, command byte layout, tx idle value.
// Used by key_spi_loader (readback gated by KEY_READBACK_EN) and key_word_asm.
package key_spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ID_MSB   = 6;
  localparam int CMD_ID_LSB   = 4;
  localparam int CMD_SK_BIT   = 3;
  localparam int CMD_ADDR_MSB = 2;
  localparam int CMD_ADDR_LSB = 0;

  localparam logic [7:0] TX_IDLE = 8'h00;

  typedef struct packed {
    logic       rw;
    logic [2:0] id;
    logic       sk;
    logic [2:0] addr;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c.rw   = b[CMD_RW_BIT];
    c.id   = b[CMD_ID_MSB:CMD_ID_LSB];
    c.sk   = b[CMD_SK_BIT];
    c.addr = b[CMD_ADDR_MSB:CMD_ADDR_LSB];
    return c;
  endfunction

  // Byte index 0 is the most significant byte, matching MSB-first transfer.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      2'd3:    r = w[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_word_asm.sv
// 32-bit MSB-first byte assembler with a 2-bit byte counter.
// The counter also paces read frames, so shifting and counting are enabled separately.
module key_word_asm
  import key_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic        count_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  cnt_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for the assembler and byte counter; clear wins over shift/count.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = 32'h0000_0000;
      cnt_d  = 2'd0;
    end else begin
      if (shift_i) begin
        word_d = {word_q[23:0], byte_i};
      end else begin
        word_d = word_q;
      end
      if (count_i) begin
        cnt_d = cnt_q + 2'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Assembler and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/key_spi_loader.sv
// SPI command decoder that bursts key words into the key register file and optionally reads them back.
// Readback of key material is enabled only when KEY_READBACK_EN is defined.
module key_spi_loader
  import key_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        rx_vld,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_byte,
  output logic        wr_en,
  output logic [31:0] wr_d,
  output logic [2:0]  wrd_id,
  output logic        wrd_sk,
  output logic [2:0]  wr_addr,
  output logic [2:0]  rd_addr,
  input  logic [31:0] rd_d,
  output logic        busy,
  output logic        frame_err
);

  logic [1:0] state_q, state_d;
  logic       armed_q, armed_d;
  logic [2:0] id_q, id_d;
  logic       sk_q, sk_d;
  logic [2:0] addr_q, addr_d;
  logic       wr_en_q, wr_en_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;
  logic [7:0] tx_q, tx_d, tx_src_s;
  logic       clr_s, shift_s, count_s;
  logic [1:0] cnt_s;
  logic [31:0] word_s;
  cmd_t       cmd_s;

  assign cmd_s = decode_cmd(rx_byte);

  key_word_asm u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_s),
    .shift_i (shift_s),
    .count_i (count_s),
    .byte_i  (rx_byte),
    .word_o  (word_s),
    .cnt_o   (cnt_s)
  );

  // Frame sequencing, address tracking and write strobe; cs_n high overrides everything.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    sk_d        = sk_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    clr_s       = 1'b0;
    shift_s     = 1'b0;
    count_s     = 1'b0;
    // A new frame needs cs_n seen high since reset, so a reset mid-frame cannot resume it.
    armed_d     = cs_n ? 1'b1 : armed_q;
    if (cs_n) begin
      state_d     = ST_IDLE;
      clr_s       = 1'b1;
      frame_err_d = (state_q == ST_WDATA) && (cnt_s != 2'd0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          clr_s = 1'b1;
          if (armed_q) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          clr_s = 1'b1;
          if (rx_vld) begin
            id_d    = cmd_s.id;
            sk_d    = cmd_s.sk;
            addr_d  = cmd_s.addr;
            state_d = cmd_s.rw ? ST_WDATA : ST_RDATA;
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_WDATA: begin
          if (rx_vld) begin
            shift_s = 1'b1;
            count_s = 1'b1;
            if (cnt_s == 2'd3) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              addr_d    = addr_q + 3'd1;
            end else begin
              wr_en_d = 1'b0;
            end
          end else begin
            shift_s = 1'b0;
          end
        end
        ST_RDATA: begin
          if (rx_vld) begin
            count_s = 1'b1;
            if (cnt_s == 2'd3) begin
              addr_d = addr_q + 3'd1;
            end else begin
              addr_d = addr_q;
            end
          end else begin
            count_s = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clr_s   = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Next transmit byte; rd_d is already addressed by the look-ahead word address.
  always_comb begin
    tx_d = TX_IDLE;
    if (cs_n) begin
      tx_d = TX_IDLE;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (rx_vld && !cmd_s.rw) begin
            tx_d = word_byte(rd_d, 2'd0);
          end else begin
            tx_d = TX_IDLE;
          end
        end
        ST_RDATA: begin
          if (rx_vld) begin
            tx_d = word_byte(rd_d, cnt_s + 2'd1);
          end else begin
            tx_d = tx_q;
          end
        end
        default: tx_d = TX_IDLE;
      endcase
    end
  end

`ifdef KEY_READBACK_EN
  assign tx_src_s = tx_d;
  assign rd_addr  = addr_d;
`else
  logic unused_rb_s;
  assign tx_src_s    = TX_IDLE;
  assign rd_addr     = 3'd0;
  assign unused_rb_s = ^tx_d;
`endif

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      id_q        <= 3'd0;
      sk_q        <= 1'b0;
      addr_q      <= 3'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 3'd0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      tx_q        <= TX_IDLE;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      id_q        <= id_d;
      sk_q        <= sk_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      tx_q        <= tx_src_s;
    end
  end

  assign tx_byte   = tx_q;
  assign wr_en     = wr_en_q;
  assign wr_d      = word_s;
  assign wrd_id    = id_q;
  assign wrd_sk    = sk_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
